// File: rtl/decode_execute_unit.sv
// MIPS ID/EX slice: main control decode and immediate generation in ID, and an
// ID/EX register feeding ALU control and the 32-bit ALU in EX.
module decode_execute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_to_reg,
    output logic [31:0] lu_out,
    output logic [3:0]  ex_alu_ctl,
    output logic        ex_sign,
    output logic [31:0] ex_alu_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_BLTZ  = 6'h01, OP_J     = 6'h02,
                           OP_JAL   = 6'h03, OP_BEQ   = 6'h04, OP_BNE   = 6'h05,
                           OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07, OP_ADDI  = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e,
                           OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                           F_JR  = 6'h08, F_JALR = 6'h09;

    localparam logic [2:0] AOP_ADD = 3'b000, AOP_SUB = 3'b001, AOP_R   = 3'b010,
                           AOP_OR  = 3'b011, AOP_AND = 3'b100, AOP_SLT = 3'b101,
                           AOP_XOR = 3'b110;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_ctl_e;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic        alu_src1;
        logic        alu_src2;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
    } id_ex_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        alu_src1;
    logic        alu_src2;
    logic        ext_op;
    logic        lu_op;
    logic [2:0]  alu_op_lo;
    logic        unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign imm           = instr[15:0];
    assign unused_fields = ^instr[25:16];

    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_src1   = 1'b0;
        alu_src2   = 1'b0;
        ext_op     = 1'b1;
        lu_op      = 1'b0;
        alu_op_lo  = AOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 2'b01;
                alu_op_lo = AOP_R;
                reg_write = (funct != F_JR);
                alu_src1  = (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);
                if (funct == F_JR || funct == F_JALR) pc_src = 2'b10;
                if (funct == F_JALR) mem_to_reg = 2'b10;
            end
            OP_BLTZ, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: alu_op_lo = AOP_SUB;
            OP_J: pc_src = 2'b01;
            OP_JAL: begin
                pc_src     = 2'b01;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            OP_ADDI, OP_ADDIU: begin
                reg_write = 1'b1;
                alu_src2  = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                reg_write = 1'b1;
                alu_src2  = 1'b1;
                alu_op_lo = AOP_SLT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                reg_write = 1'b1;
                alu_src2  = 1'b1;
                ext_op    = 1'b0;
                alu_op_lo = (opcode == OP_ANDI) ? AOP_AND :
                            (opcode == OP_ORI)  ? AOP_OR  : AOP_XOR;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src2  = 1'b1;
                lu_op     = 1'b1;
            end
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src2   = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 2'b01;
            end
            OP_SW: begin
                alu_src2  = 1'b1;
                mem_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign lu_out = lu_op  ? {imm, 16'h0000} :
                    ext_op ? {{16{imm[15]}}, imm} : {16'h0000, imm};

    // A flushed stage is indistinguishable from a reset one: all-zero fields.
    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    always_comb begin
        id_ex_d = '0;
        if (!flush) begin
            id_ex_d.alu_op   = {opcode[0], alu_op_lo};
            id_ex_d.funct    = funct;
            id_ex_d.shamt    = instr[10:6];
            id_ex_d.alu_src1 = alu_src1;
            id_ex_d.alu_src2 = alu_src2;
            id_ex_d.rs       = rs_data;
            id_ex_d.rt       = rt_data;
            id_ex_d.imm      = lu_out;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) id_ex_q <= '0;
        else       id_ex_q <= id_ex_d;
    end

    logic        ex_is_r;
    alu_ctl_e    alu_ctl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        slt_bit;

    assign ex_is_r = (id_ex_q.alu_op[2:0] == AOP_R);
    assign ex_sign = ex_is_r ? ~id_ex_q.funct[0] : ~id_ex_q.alu_op[3];

    always_comb begin
        alu_ctl = ALU_ADD;
        case (id_ex_q.alu_op[2:0])
            AOP_R: begin
                case (id_ex_q.funct)
                    6'h22, 6'h23: alu_ctl = ALU_SUB;
                    6'h24:        alu_ctl = ALU_AND;
                    6'h25:        alu_ctl = ALU_OR;
                    6'h26:        alu_ctl = ALU_XOR;
                    6'h27:        alu_ctl = ALU_NOR;
                    6'h2a, 6'h2b: alu_ctl = ALU_SLT;
                    F_SLL:        alu_ctl = ALU_SLL;
                    F_SRL:        alu_ctl = ALU_SRL;
                    F_SRA:        alu_ctl = ALU_SRA;
                    default:      alu_ctl = ALU_ADD;
                endcase
            end
            AOP_SUB: alu_ctl = ALU_SUB;
            AOP_AND: alu_ctl = ALU_AND;
            AOP_OR:  alu_ctl = ALU_OR;
            AOP_XOR: alu_ctl = ALU_XOR;
            AOP_SLT: alu_ctl = ALU_SLT;
            default: alu_ctl = ALU_ADD;
        endcase
    end

    assign ex_alu_ctl = alu_ctl;
    assign in1 = id_ex_q.alu_src1 ? {27'b0, id_ex_q.shamt} : id_ex_q.rs;
    assign in2 = id_ex_q.alu_src2 ? id_ex_q.imm : id_ex_q.rt;
    assign slt_bit = ex_sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    always_comb begin
        ex_alu_out = '0;
        case (alu_ctl)
            ALU_ADD: ex_alu_out = in1 + in2;
            ALU_SUB: ex_alu_out = in1 - in2;
            ALU_AND: ex_alu_out = in1 & in2;
            ALU_OR:  ex_alu_out = in1 | in2;
            ALU_XOR: ex_alu_out = in1 ^ in2;
            ALU_NOR: ex_alu_out = ~(in1 | in2);
            ALU_SLT: ex_alu_out = {31'b0, slt_bit};
            ALU_SLL: ex_alu_out = in2 << in1[4:0];
            ALU_SRL: ex_alu_out = in2 >> in1[4:0];
            ALU_SRA: ex_alu_out = $unsigned($signed(in2) >>> in1[4:0]);
            default: ex_alu_out = '0;
        endcase
    end

endmodule

// File: tb/tb_decode_execute_unit.sv
// Randomized self-checking bench for decode_execute_unit against an
// instruction-semantics reference model.
module tb_decode_execute_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_to_reg;
    logic [31:0] lu_out;
    logic [3:0]  ex_alu_ctl;
    logic        ex_sign;
    logic [31:0] ex_alu_out;

    int checks = 0;
    int errors = 0;

    decode_execute_unit dut (
        .clk(clk), .reset(reset), .instr(instr), .rs_data(rs_data),
        .rt_data(rt_data), .flush(flush), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .lu_out(lu_out), .ex_alu_ctl(ex_alu_ctl),
        .ex_sign(ex_sign), .ex_alu_out(ex_alu_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  pc_src;
        logic        reg_write;
        logic [1:0]  reg_dst;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_to_reg;
        logic [31:0] lu_out;
    } id_exp_t;

    typedef struct packed {
        logic [3:0]  ctl;
        logic        sign;
        logic [31:0] result;
    } ex_exp_t;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] slt_s(input logic [31:0] a, input logic [31:0] b);
        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] slt_u(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? 32'd1 : 32'd0;
    endfunction

    function automatic id_exp_t model_id(input logic [31:0] i);
        id_exp_t     r;
        logic [5:0]  op = i[31:26];
        logic [5:0]  fn = i[5:0];
        logic [15:0] im = i[15:0];
        logic is_r  = (op == 6'h00);
        logic is_br = (op == 6'h01) || (op >= 6'h04 && op <= 6'h07);
        logic sup   = (op <= 6'h0f) || (op == 6'h23) || (op == 6'h2b);
        r.pc_src     = (op == 6'h02 || op == 6'h03) ? 2'd1 :
                       (is_r && (fn == 6'h08 || fn == 6'h09)) ? 2'd2 : 2'd0;
        r.reg_write  = sup && !(op == 6'h2b || op == 6'h02 || is_br || (is_r && fn == 6'h08));
        r.reg_dst    = is_r ? 2'd1 : (op == 6'h03) ? 2'd2 : 2'd0;
        r.mem_read   = (op == 6'h23);
        r.mem_write  = (op == 6'h2b);
        r.mem_to_reg = (op == 6'h23) ? 2'd1 : (op == 6'h03 || (is_r && fn == 6'h09)) ? 2'd2 : 2'd0;
        r.lu_out     = (op == 6'h0f) ? {im, 16'h0000} :
                       (op >= 6'h0c && op <= 6'h0e) ? {16'h0000, im} : sext(im);
        return r;
    endfunction

    // Expected EX result straight from each instruction's meaning.
    function automatic ex_exp_t model_ex(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        ex_exp_t     r;
        logic [5:0]  op = i[31:26];
        logic [5:0]  fn = i[5:0];
        logic [4:0]  sh = i[10:6];
        logic [31:0] se = sext(i[15:0]);
        logic [31:0] ze = {16'h0000, i[15:0]};
        r.sign = ~op[0];
        r.ctl = 4'd0;
        r.result = a + b;
        if (op == 6'h00) begin
            r.sign = ~fn[0];
            case (fn)
                6'h22, 6'h23: begin r.ctl = 4'd1; r.result = a - b; end
                6'h24: begin r.ctl = 4'd2; r.result = a & b; end
                6'h25: begin r.ctl = 4'd3; r.result = a | b; end
                6'h26: begin r.ctl = 4'd4; r.result = a ^ b; end
                6'h27: begin r.ctl = 4'd5; r.result = ~(a | b); end
                6'h2a: begin r.ctl = 4'd6; r.result = slt_s(a, b); end
                6'h2b: begin r.ctl = 4'd6; r.result = slt_u(a, b); end
                6'h00: begin r.ctl = 4'd7; r.result = b << sh; end
                6'h02: begin r.ctl = 4'd8; r.result = b >> sh; end
                6'h03: begin r.ctl = 4'd9; r.result = $unsigned($signed(b) >>> sh); end
                default: r.result = a + b;
            endcase
        end else begin
            case (op)
                6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin r.ctl = 4'd1; r.result = a - b; end
                6'h08, 6'h09, 6'h23, 6'h2b: r.result = a + se;
                6'h0a: begin r.ctl = 4'd6; r.result = slt_s(a, se); end
                6'h0b: begin r.ctl = 4'd6; r.result = slt_u(a, se); end
                6'h0c: begin r.ctl = 4'd2; r.result = a & ze; end
                6'h0d: begin r.ctl = 4'd3; r.result = a | ze; end
                6'h0e: begin r.ctl = 4'd4; r.result = a ^ ze; end
                6'h0f: r.result = a + {i[15:0], 16'h0000};
                default: r.result = a + b;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [15:0] im);
        return {op, 5'd1, 5'd2, im};
    endfunction

    task automatic check_ex_zero(input string tag);
        check({tag, "_ctl"}, ex_alu_ctl, 32'd0);
        check({tag, "_sign"}, ex_sign, 32'd1);
        check({tag, "_out"}, ex_alu_out, 32'd0);
    endtask

    // Drive at the falling edge, check ID mid-cycle, check EX after the next rising edge.
    task automatic run_instr(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic fl);
        id_exp_t ide;
        ex_exp_t exe;
        @(negedge clk);
        instr = i; rs_data = a; rt_data = b; flush = fl;
        #1;
        ide = model_id(i);
        check("pc_src", pc_src, ide.pc_src);
        check("reg_write", reg_write, ide.reg_write);
        check("reg_dst", reg_dst, ide.reg_dst);
        check("mem_read", mem_read, ide.mem_read);
        check("mem_write", mem_write, ide.mem_write);
        check("mem_to_reg", mem_to_reg, ide.mem_to_reg);
        check("lu_out", lu_out, ide.lu_out);
        exe = fl ? '{ctl: 4'd0, sign: 1'b1, result: 32'd0} : model_ex(i, a, b);
        @(posedge clk);
        #1;
        check("ex_alu_ctl", ex_alu_ctl, exe.ctl);
        check("ex_sign", ex_sign, exe.sign);
        check("ex_alu_out", ex_alu_out, exe.result);
    endtask

    logic [5:0] ops [20] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                             6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                             6'h23, 6'h2b, 6'h00, 6'h00};
    logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                             6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h01};

    initial begin
        reset = 1'b1; instr = '0; rs_data = '0; rt_data = '0; flush = 1'b0;
        #1;
        check_ex_zero("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_instr(i_ins(6'h08, 16'hFFFF), 32'd5, 32'd0, 1'b0);
        check("addi_rw", reg_write, 32'd1);
        check("addi_lu", lu_out, 32'hFFFFFFFF);
        check("addi_out", ex_alu_out, 32'd4);
        run_instr(r_ins(6'h2a, 5'd0), 32'hFFFFFFFF, 32'd1, 1'b0);
        check("slt_out", ex_alu_out, 32'd1);
        run_instr(r_ins(6'h2b, 5'd0), 32'hFFFFFFFF, 32'd1, 1'b0);
        check("sltu_sign", ex_sign, 32'd0);
        check("sltu_out", ex_alu_out, 32'd0);
        run_instr(r_ins(6'h03, 5'd4), 32'd0, 32'h80000000, 1'b0);
        check("sra_ctl", ex_alu_ctl, 32'd9);
        check("sra_out", ex_alu_out, 32'hF8000000);
        run_instr(i_ins(6'h0f, 16'h1234), 32'd0, 32'd0, 1'b0);
        check("lui_out", ex_alu_out, 32'h12340000);
        run_instr(i_ins(6'h0c, 16'h8000), 32'hFFFFFFFF, 32'd0, 1'b0);
        check("andi_out", ex_alu_out, 32'h00008000);
        run_instr({6'h03, 26'h0000100}, 32'd1, 32'd2, 1'b0);
        check("jal_pc", pc_src, 32'd1);
        run_instr(r_ins(6'h08, 5'd0), 32'd1, 32'd2, 1'b0);
        check("jr_pc", pc_src, 32'd2);
        run_instr(i_ins(6'h23, 16'h0010), 32'h100, 32'd0, 1'b0);
        check("lw_mr", mem_read, 32'd1);
        run_instr(i_ins(6'h2b, 16'hFFF0), 32'h100, 32'd0, 1'b0);
        check("sw_mw", mem_write, 32'd1);
        run_instr(i_ins(6'h3f, 16'h1111), 32'd3, 32'd4, 1'b0);

        // Flush turns a live instruction into a bubble.
        run_instr(i_ins(6'h0d, 16'h00F0), 32'h0F00_0000, 32'd0, 1'b1);
        check_ex_zero("flush");

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri;
            ri = {ops[$urandom_range(19)], 26'($urandom)};
            if ($urandom_range(7) == 0) ri[31:26] = 6'($urandom);
            if (ri[31:26] == 6'h00) ri[5:0] = fns[$urandom_range(15)];
            run_instr(ri, ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom,
                      $urandom, ($urandom_range(15) == 0));
        end

        // Asynchronous reset in mid-cycle discards the in-flight result at once.
        run_instr(r_ins(6'h20, 5'd0), 32'd100, 32'd23, 1'b0);
        check("pre_reset_out", ex_alu_out, 32'd123);
        #2;
        reset = 1'b1;
        #1;
        check_ex_zero("async_reset");
        @(posedge clk); #1;
        check_ex_zero("reset_held");
        @(negedge clk);
        reset = 1'b0;
        run_instr(r_ins(6'h22, 5'd0), 32'd10, 32'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
